hex_display_decoder: RTL and testbench

- Receive-side counterpart of the 4-digit multiplexed 7-segment driver: watches the DS_EN1..4 / DS_A..G lines and reconstructs the hex value currently shown on each digit.
- Used in benches and on-chip self-check as a scoreboard monitor for the display top, and as a loopback checker on the board.
- Sits alongside the display top and samples its outputs on the same clk.

---
 rtl/hex_display_pkg.sv | 31 +++
 rtl/hex_display_decoder_seg7.sv | 39 +++
 rtl/hex_display_decoder.sv | 147 ++++++++++++++
 tb/tb_hex_display_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the 7-segment display decoder: glyph patterns (gfedcba,
// lit = 1), the capture FSM encoding and the digit count.
package hex_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/hex_display_decoder_seg7.sv
// Combinational glyph decoder: maps a lit-high segment pattern to its hex value.
// Only the exact glyph patterns count as hits; all-off is reported as blank.
module seg7_to_hex
  import hex_display_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] val
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (seg)
      SEG_0:   val = 4'h0;
      SEG_1:   val = 4'h1;
      SEG_2:   val = 4'h2;
      SEG_3:   val = 4'h3;
      SEG_4:   val = 4'h4;
      SEG_5:   val = 4'h5;
      SEG_6:   val = 4'h6;
      SEG_7:   val = 4'h7;
      SEG_8:   val = 4'h8;
      SEG_9:   val = 4'h9;
      SEG_A:   val = 4'hA;
      SEG_B:   val = 4'hB;
      SEG_C:   val = 4'hC;
      SEG_D:   val = 4'hD;
      SEG_E:   val = 4'hE;
      SEG_F:   val = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/hex_display_decoder.sv
// Monitors a multiplexed 4-digit 7-segment bus and reconstructs the value on
// each digit once a one-hot enable and its segment pattern have held steady.
module hex_display_decoder
  import hex_display_pkg::*;
#(
  parameter int SETTLE         = 4,
  parameter bit EN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   ds_en,
  input  logic [6:0]              ds_seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic                    bad_pattern,
  output logic [1:0]              bad_digit,
  output logic                    frame_done
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_e                    r_state, w_state_next;
  logic [NUM_DIGITS-1:0]     r_en_q, r_ref_en, r_seen, r_valid, r_blank;
  logic [6:0]                r_seg_q, r_ref_seg;
  logic [7:0]                r_cnt, w_cnt_inc;
  logic [4*NUM_DIGITS-1:0]   r_digits;
  logic                      r_update, r_bad, r_frame;
  logic [1:0]                r_bad_digit, w_idx;
  logic [NUM_DIGITS-1:0]     w_en_n, w_seen_next;
  logic [6:0]                w_seg_n;
  logic                      w_onehot, w_match, w_arm, w_advance, w_capture;
  logic                      w_hit, w_blank;
  logic [3:0]                w_val;

  assign w_en_n  = ds_en ^ {NUM_DIGITS{EN_ACTIVE_LOW}};
  assign w_seg_n = ds_seg ^ {7{SEG_ACTIVE_LOW}};

  assign w_onehot = $onehot(r_en_q);
  assign w_match  = (r_en_q == r_ref_en) && (r_seg_q == r_ref_seg);

  always_comb begin
    w_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_en_q[i]) w_idx = 2'(i);
    end
  end

  // Capture always happens with en_q/seg_q equal to the reference, so the
  // live sample drives the glyph decoder directly.
  seg7_to_hex u_seg7_to_hex (
    .seg   (r_seg_q),
    .hit   (w_hit),
    .blank (w_blank),
    .val   (w_val)
  );

  // NOTE: this FSM is synchronously reset; rst is only sampled inside the clocked block, never in its sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Output decode: arming from IDLE or any change, counting while stable.
  always_comb begin
    w_arm     = w_onehot && ((r_state == ST_IDLE) || !w_match);
    w_advance = (r_state == ST_SETTLE) && w_match;
    w_cnt_inc = (r_cnt >= SETTLE_CNT) ? SETTLE_CNT : r_cnt + 8'd1;
    w_capture = (w_arm && (SETTLE_CNT == 8'd1)) ||
                (w_advance && (w_cnt_inc == SETTLE_CNT));
  end

  always_comb begin
    w_state_next = ST_IDLE;
    if (w_capture)                               w_state_next = ST_HOLD;
    else if (w_arm || w_advance)                 w_state_next = ST_SETTLE;
    else if ((r_state == ST_HOLD) && w_match)    w_state_next = ST_HOLD;
  end

  assign w_seen_next = r_seen | (NUM_DIGITS'(1) << w_idx);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q      <= '0;
      r_seg_q     <= '0;
      r_ref_en    <= '0;
      r_ref_seg   <= '0;
      r_cnt       <= '0;
      r_seen      <= '0;
      r_digits    <= '0;
      r_valid     <= '0;
      r_blank     <= '0;
      r_update    <= 1'b0;
      r_bad       <= 1'b0;
      r_bad_digit <= 2'd0;
      r_frame     <= 1'b0;
    end else begin
      r_en_q   <= w_en_n;
      r_seg_q  <= w_seg_n;
      r_update <= 1'b0;
      r_bad    <= 1'b0;
      r_frame  <= 1'b0;

      if (w_arm) begin
        r_ref_en  <= r_en_q;
        r_ref_seg <= r_seg_q;
        r_cnt     <= 8'd1;
      end else if (w_advance) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_capture) begin
        if (w_hit || w_blank) begin
          if (w_hit) begin
            r_digits[{w_idx, 2'b00} +: 4] <= w_val;
            r_valid[w_idx]                <= 1'b1;
            r_blank[w_idx]                <= 1'b0;
          end else begin
            r_blank[w_idx] <= 1'b1;
          end
          r_update <= 1'b1;
          if (w_seen_next == {NUM_DIGITS{1'b1}}) begin
            r_frame <= 1'b1;
            r_seen  <= '0;
          end else begin
            r_seen <= w_seen_next;
          end
        end else begin
          r_bad       <= 1'b1;
          r_bad_digit <= w_idx;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign digit_blank = r_blank;
  assign update      = r_update;
  assign bad_pattern = r_bad;
  assign bad_digit   = r_bad_digit;
  assign frame_done  = r_frame;

endmodule

// File: tb/tb_hex_display_decoder.sv
// Scoreboard bench for hex_display_decoder: a run-length reference model predicts
// each capture event, a negedge monitor pops and compares against the DUT.
module tb_hex_display_decoder;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ds_en = 4'hF;
  logic [6:0]  ds_seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_valid, digit_blank;
  logic        update, bad_pattern, frame_done;
  logic [1:0]  bad_digit;

  hex_display_decoder #(.SETTLE(SETTLE), .EN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ds_en       (ds_en),
    .ds_seg      (ds_seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .update      (update),
    .bad_pattern (bad_pattern),
    .bad_digit   (bad_digit),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected display glyphs, indexed by hex value.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int          cyc;
    logic        upd, bad, fd;
    logic [15:0] dig;
    logic [3:0]  valid, blank;
    logic [1:0]  bad_digit;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: a capture is due when the registered sample is one-hot and
  // has held exactly SETTLE consecutive cycles.
  int         cyc = 0;
  logic [3:0] m_en = '0;
  logic [6:0] m_seg = '0;
  int         m_run = 0;
  logic [3:0] m_dig [4] = '{default: 4'h0};
  logic [3:0] m_valid = '0, m_blank = '0, m_seen = '0;
  logic [1:0] m_bad_digit = '0;

  always @(posedge clk) begin
    exp_t e;
    int   idx;
    int   v;
    cyc++;
    if (rst) begin
      m_en = '0; m_seg = '0; m_run = 1;
      m_dig = '{default: 4'h0};
      m_valid = '0; m_blank = '0; m_seen = '0; m_bad_digit = '0;
    end else begin
      if ($countones(m_en) == 1 && m_run == SETTLE) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (m_en[i]) idx = i;
        v = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == m_seg) v = g;
        e.upd = 1'b0; e.bad = 1'b0; e.fd = 1'b0;
        if (v >= 0 || m_seg == 7'h00) begin
          if (v >= 0) begin
            m_dig[idx] = 4'(v);
            m_valid[idx] = 1'b1;
            m_blank[idx] = 1'b0;
          end else begin
            m_blank[idx] = 1'b1;
          end
          e.upd = 1'b1;
          m_seen[idx] = 1'b1;
          if (m_seen == 4'hF) begin
            e.fd = 1'b1;
            m_seen = '0;
          end
        end else begin
          e.bad = 1'b1;
          m_bad_digit = 2'(idx);
        end
        e.cyc = cyc;
        e.dig = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        e.valid = m_valid;
        e.blank = m_blank;
        e.bad_digit = m_bad_digit;
        sb_q.push_back(e);
      end
      if (~ds_en == m_en && ~ds_seg == m_seg) begin
        m_run++;
      end else begin
        m_en = ~ds_en;
        m_seg = ~ds_seg;
        m_run = 1;
      end
    end
  end

  int n_update = 0, n_bad = 0, n_fd = 0;

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (update)      n_update++;
      if (bad_pattern) n_bad++;
      if (frame_done)  n_fd++;
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        check($sformatf("event cyc=%0d", e.cyc),
              {35'd0, update, bad_pattern, frame_done, digits, digit_valid, digit_blank, bad_digit},
              {35'd0, e.upd, e.bad, e.fd, e.dig, e.valid, e.blank, e.bad_digit});
      end else begin
        check($sformatf("no pulse cyc=%0d", cyc), {61'd0, update, bad_pattern, frame_done}, 64'd0);
      end
    end
  end

  // Drives active-high (normalised) enable/segment values for n cycles.
  task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int n);
    ds_en  = ~en;
    ds_seg = ~seg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int u0, b0, f0, at, cnt;
    repeat (3) @(negedge clk);
    check("reset outputs", {update, bad_pattern, frame_done, bad_digit, digits, digit_valid, digit_blank},
          '0);
    rst = 1'b0;
    drive(4'b0000, 7'h00, 3);

    // Steady digit 0 showing 3: exactly one capture, SETTLE+1 cycles in.
    ds_en = 4'b1110; ds_seg = ~7'h4F;
    cnt = 0; at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (update) begin cnt++; if (at == 0) at = i; end
    end
    check("steady update count", cnt, 1);
    check("steady update latency", at, SETTLE + 1);
    check("steady digit0", digits[3:0], 4'h3);
    check("steady valid", digit_valid, 4'b0001);

    // Full frame 1, A, b, F.
    u0 = n_update; f0 = n_fd;
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h77, 8);
    drive(4'b0100, 7'h7C, 8);
    drive(4'b1000, 7'h71, 8);
    check("frame updates", n_update - u0, 4);
    check("frame frame_done", n_fd - f0, 1);
    check("frame digits", digits, 16'hFBA1);
    check("frame valid", digit_valid, 4'hF);

    // Short activation must not capture, a long one must.
    u0 = n_update;
    drive(4'b0100, 7'h7F, 3);
    drive(4'b0000, 7'h7F, 2);
    check("short activation", n_update - u0, 0);
    drive(4'b0100, 7'h7F, 6);
    check("long activation", digits, 16'hF8A1);

    // Ghosting: two enables, then none.
    u0 = n_update; b0 = n_bad;
    drive(4'b0011, 7'h7F, 20);
    drive(4'b0000, 7'h7F, 20);
    check("ghost updates", n_update - u0, 0);
    check("ghost bad", n_bad - b0, 0);
    check("ghost digits", digits, 16'hF8A1);

    // Non-glyph then blank on digit 1.
    u0 = n_update; b0 = n_bad;
    drive(4'b0010, 7'h01, 8);
    check("bad pulse", n_bad - b0, 1);
    check("bad digit", bad_digit, 2'd1);
    check("bad no update", n_update - u0, 0);
    drive(4'b0010, 7'h00, 8);
    check("blank flag", digit_blank[1], 1'b1);
    check("blank digit kept", digits[7:4], 4'hA);

    // Reset during the third settle cycle; capture restarts afterwards.
    ds_en = ~4'b1000; ds_seg = ~7'h6D;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-settle reset", {update, bad_pattern, frame_done, bad_digit, digits, digit_valid, digit_blank},
          '0);
    rst = 1'b0;
    at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (update) begin at = i; break; end
    end
    check("post-reset latency", at, SETTLE + 1);
    check("post-reset digits", {digits, digit_valid}, {16'h5000, 4'b1000});

    // Randomised traffic checked by the scoreboard.
    for (int k = 0; k < 300; k++) begin
      logic [3:0] en;
      logic [6:0] seg;
      int kind;
      kind = $urandom_range(0, 9);
      en   = 4'b0001 << $urandom_range(0, 3);
      seg  = glyph[$urandom_range(0, 15)];
      if (kind == 6) seg = 7'h00;
      if (kind == 7) seg = 7'($urandom);
      if (kind == 8) begin
        en = 4'($urandom);
        if ($countones(en) == 1) en = ~en;
      end
      if (kind == 9) en = 4'b0000;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(en, seg, $urandom_range(1, 8));
    end

    drive(4'b0000, 7'h00, 10);
    check("scoreboard drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
